logic_op_arbiter: RTL and testbench
===================================

LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits.
REQ-002 Port clock, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-004 Port req_valid, input, 3, SHALL carry one request-valid bit per requester (index 0..2).
REQ-005 Port req_ready, output, 3, SHALL be the one-hot accept per requester.
REQ-006 Port req_op, input, 6, SHALL carry 2 bits per requester: 00 AND, 01 OR, 10 XOR, 11 reserved.
REQ-007 Ports req_a and req_b, input, 3*WIDTH each, SHALL carry the operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port rsp_valid, output, 1, SHALL flag a valid response.
REQ-009 Port rsp_ready, input, 1, SHALL be the consumer accept.
REQ-010 Port rsp_id, output, 2, SHALL give the requester index of the response.
REQ-011 Port rsp_data, output, WIDTH, SHALL give the registered result.
REQ-012 Port rsp_err, output, 1, SHALL flag a reserved opcode.
REQ-013 Port busy, output, 1, SHALL be high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, EXEC and RESP, with encoded transitions IDLE->EXEC->RESP->IDLE.
REQ-015 In IDLE with any req_valid set, req_ready SHALL combinationally assert one-hot on the round-robin winner; it is zero in all other states.
REQ-016 Round-robin: the search starts at index (last_grant+1) mod 3; last_grant updates only on an accepted request.
REQ-017 On accept (req_valid[i] & req_ready[i]), the block SHALL capture op, a, b and index i, and move to EXEC.
REQ-018 In EXEC, the block SHALL compute the result: AND a&b, OR a|b, XOR a^b; opcode 11 gives all-zero data with rsp_err=1.
REQ-019 The block SHALL register the result into rsp_data, rsp_id and rsp_err, set rsp_valid, and move to RESP.
REQ-020 Latency: for an accept in cycle N, rsp_valid SHALL be high in cycle N+2.
REQ-021 In RESP, rsp_valid, rsp_data, rsp_id and rsp_err SHALL hold stable until rsp_ready=1.
REQ-022 On the rsp_valid & rsp_ready edge, rsp_valid SHALL clear and the FSM SHALL return to IDLE; the earliest next accept is the following cycle.
REQ-023 Changes to req_* inputs after accept SHALL NOT affect the in-flight result.
REQ-024 A requester that drops req_valid before it is granted SHALL NOT be served; no request is queued.
REQ-025 If all three requesters are valid continuously, grants SHALL rotate 0,1,2,0,...

Reset
REQ-026 Asserting reset_n low SHALL immediately force the following: state IDLE, last_grant=2 (so requester 0 has first priority), rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0.
REQ-027 A reset asserted mid-operation SHALL discard the in-flight request without producing a response.

Configuration
REQ-028 Macro LOGIC_OP_STATS_EN SHALL control the statistics feature.
REQ-029 With LOGIC_OP_STATS_EN defined, the block SHALL add output op_count (16 bits).
REQ-030 op_count SHALL increment once per completed response handshake, saturate at 16'hFFFF, and reset to 0.
REQ-031 Without LOGIC_OP_STATS_EN, the op_count port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-032 After reset, req_valid=3'b001, op=00, a=8'h0F, b=8'h3C, rsp_ready=1 -> req_ready=3'b001 at N; rsp_valid at N+2 with rsp_data=8'h0C, rsp_id=0, rsp_err=0.
REQ-033 With rsp_ready held low, op=01 (a=8'h0F, b=8'h3C) -> rsp_data=8'h3F held stable for 5 cycles; rsp_ready=1 -> rsp_valid clears, busy=0 next cycle.
REQ-034 req_valid=3'b111 held for 4 transactions -> grant order 0,1,2,0; op=10 with a=8'hFF, b=8'h0F -> rsp_data=8'hF0.
REQ-035 op=11 with a=8'hAA, b=8'h55 -> rsp_data=8'h00, rsp_err=1.
REQ-036 reset_n pulsed low in EXEC -> no response; rsp_valid=0; the next request from requester 1 alone is granted.
REQ-037 With LOGIC_OP_STATS_EN defined, 3 completed handshakes -> op_count=3; with the macro undefined the bench compiles without op_count.

Source files
------------

// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: three-requester round-robin arbiter that performs a
// bitwise AND/OR/XOR on the granted requester's operands and returns a
// registered response through a valid/ready handshake.
// Optional feature: define LOGIC_OP_STATS_EN to add the 16-bit saturating
// op_count output that counts completed response handshakes.

module logic_op_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [2:0]         req_valid,
    output logic [2:0]         req_ready,
    input  logic [5:0]         req_op,
    input  logic [3*WIDTH-1:0] req_a,
    input  logic [3*WIDTH-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_id,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err,
    output logic               busy
`ifdef LOGIC_OP_STATS_EN
    ,
    output logic [15:0]        op_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         last_grant;
    logic [1:0]         rr_start;
    logic               sel_found;
    logic [1:0]         sel_idx;
    logic [2:0]         cand;
    logic [1:0]         sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [1:0]         cap_op;
    logic [WIDTH-1:0]   cap_a;
    logic [WIDTH-1:0]   cap_b;
    logic [1:0]         cap_id;
    logic [WIDTH-1:0]   exec_data;
    logic               exec_err;

    // Search begins one past the most recently granted requester, wrapping 2 -> 0
    always_comb begin
        rr_start = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
    end

    // Round-robin winner: first valid requester in rotated order from rr_start
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        cand      = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, rr_start} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!sel_found && req_valid[cand[1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[1:0];
            end
        end
    end

    // Route the winner's opcode and operands to the capture registers
    always_comb begin
        sel_op = 2'b00;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < 3; i++) begin
            if (sel_idx == 2'(i)) begin
                sel_op = req_op[i*2 +: 2];
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Grant is offered only while idle, so at most one request is ever in flight
    always_comb begin
        req_ready = 3'b000;
        if (state == IDLE && sel_found) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    // Bitwise operation on the captured operands; the reserved opcode yields zero plus an error flag
    always_comb begin
        exec_data = '0;
        exec_err  = 1'b0;
        case (cap_op)
            2'b00:   exec_data = cap_a & cap_b;
            2'b01:   exec_data = cap_a | cap_b;
            2'b10:   exec_data = cap_a ^ cap_b;
            default: exec_err  = 1'b1;
        endcase
    end

    // Control FSM: capture on grant, register the result, then hold it until the consumer accepts
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 2'd2;
            cap_op     <= 2'b00;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_id     <= 2'd0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 2'd0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        cap_op     <= sel_op;
                        cap_a      <= sel_a;
                        cap_b      <= sel_b;
                        cap_id     <= sel_idx;
                        last_grant <= sel_idx;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= exec_data;
                    rsp_err   <= exec_err;
                    rsp_id    <= cap_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Busy whenever a request is being processed or its response is pending
    always_comb begin
        busy = (state != IDLE);
    end

`ifdef LOGIC_OP_STATS_EN
    // Count completed response handshakes, sticking at the maximum value
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_count <= 16'h0000;
        end else if (rsp_valid && rsp_ready && op_count != 16'hFFFF) begin
            op_count <= op_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb_logic_op_arbiter: directed self-checking bench for logic_op_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
// Define LOGIC_OP_STATS_EN to also exercise the op_count output.

module tb_logic_op_arbiter;

    logic        clock;
    logic        reset_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [5:0]  req_op;
    logic [23:0] req_a;
    logic [23:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;
`ifdef LOGIC_OP_STATS_EN
    logic [15:0] op_count;
`endif

    int checks;
    int passes;

    logic_op_arbiter #(.WIDTH(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
`ifdef LOGIC_OP_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    // Free-running 100 MHz clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic pulse_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 3'b000;
        req_op    = 6'b000000;
        req_a     = 24'h0;
        req_b     = 24'h0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else passes++;
        checks++; if (rsp_data !== 8'h00) $display("[TB] FAIL reset_rsp_data: got %h expected 00", rsp_data); else passes++;
        checks++; if (rsp_id !== 2'd0) $display("[TB] FAIL reset_rsp_id: got %0d expected 0", rsp_id); else passes++;
        checks++; if (rsp_err !== 1'b0) $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (req_ready !== 3'b000) $display("[TB] FAIL reset_req_ready: got %b expected 000", req_ready); else passes++;
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // AND from requester 0 with two-cycle latency
    task automatic test_and();
        req_valid = 3'b001;
        req_op    = 6'b000000;
        req_a     = {16'h0, 8'h0F};
        req_b     = {16'h0, 8'h3C};
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b001) $display("[TB] FAIL and_grant: got %b expected 001", req_ready); else passes++;
        @(negedge clock);
        req_valid = 3'b000;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL and_busy_exec: got %b expected 1", busy); else passes++;
        checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL and_early_valid: got %b expected 0", rsp_valid); else passes++;
        @(negedge clock);
        checks++; if (rsp_valid !== 1'b1) $display("[TB] FAIL and_valid_n2: got %b expected 1", rsp_valid); else passes++;
        checks++; if (rsp_data !== 8'h0C) $display("[TB] FAIL and_data: got %h expected 0c", rsp_data); else passes++;
        checks++; if (rsp_id !== 2'd0) $display("[TB] FAIL and_id: got %0d expected 0", rsp_id); else passes++;
        checks++; if (rsp_err !== 1'b0) $display("[TB] FAIL and_err: got %b expected 0", rsp_err); else passes++;
        @(negedge clock);
        checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL and_valid_clear: got %b expected 0", rsp_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL and_busy_idle: got %b expected 0", busy); else passes++;
    endtask

    // OR held under backpressure; inputs scrambled after accept must not leak in
    task automatic test_hold();
        req_valid = 3'b001;
        req_op    = 6'b000001;
        req_a     = {16'h0, 8'h0F};
        req_b     = {16'h0, 8'h3C};
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 3'b001) $display("[TB] FAIL hold_grant: got %b expected 001", req_ready); else passes++;
        @(negedge clock);
        req_valid = 3'b000;
        req_op    = 6'b111111;
        req_a     = 24'hFFFFFF;
        req_b     = 24'h000000;
        @(negedge clock);
        for (int c = 0; c < 5; c++) begin
            checks++; if (rsp_valid !== 1'b1) $display("[TB] FAIL hold_valid_c%0d: got %b expected 1", c, rsp_valid); else passes++;
            checks++; if (rsp_data !== 8'h3F) $display("[TB] FAIL hold_data_c%0d: got %h expected 3f", c, rsp_data); else passes++;
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL hold_valid_clear: got %b expected 0", rsp_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL hold_busy_clear: got %b expected 0", busy); else passes++;
    endtask

    // All three requesters valid: grants rotate 0,1,2,0 with back-to-back accepts
    task automatic test_round_robin();
        logic [1:0] exp_id   [4];
        logic [7:0] exp_data [4];
        exp_id   = '{2'd0, 2'd1, 2'd2, 2'd0};
        exp_data = '{8'hF0, 8'hCC, 8'hAA, 8'hF0};
        pulse_reset();
        req_op    = 6'b101010;
        req_a     = {8'hFF, 8'hFF, 8'hFF};
        req_b     = {8'h55, 8'h33, 8'h0F};
        rsp_ready = 1'b1;
        req_valid = 3'b111;
        #1;
        for (int t = 0; t < 4; t++) begin
            checks++; if (req_ready !== (3'b001 << exp_id[t])) $display("[TB] FAIL rr_grant_t%0d: got %b expected %b", t, req_ready, 3'b001 << exp_id[t]); else passes++;
            @(negedge clock);
            @(negedge clock);
            checks++; if (rsp_id !== exp_id[t]) $display("[TB] FAIL rr_id_t%0d: got %0d expected %0d", t, rsp_id, exp_id[t]); else passes++;
            checks++; if (rsp_data !== exp_data[t]) $display("[TB] FAIL rr_data_t%0d: got %h expected %h", t, rsp_data, exp_data[t]); else passes++;
            @(negedge clock);
        end
        req_valid = 3'b000;
    endtask

    // Reserved opcode from requester 1
    task automatic test_reserved();
        req_valid = 3'b010;
        req_op    = 6'b001100;
        req_a     = {8'h00, 8'hAA, 8'h00};
        req_b     = {8'h00, 8'h55, 8'h00};
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b010) $display("[TB] FAIL rsv_grant: got %b expected 010", req_ready); else passes++;
        @(negedge clock);
        req_valid = 3'b000;
        @(negedge clock);
        checks++; if (rsp_valid !== 1'b1) $display("[TB] FAIL rsv_valid: got %b expected 1", rsp_valid); else passes++;
        checks++; if (rsp_data !== 8'h00) $display("[TB] FAIL rsv_data: got %h expected 00", rsp_data); else passes++;
        checks++; if (rsp_err !== 1'b1) $display("[TB] FAIL rsv_err: got %b expected 1", rsp_err); else passes++;
        checks++; if (rsp_id !== 2'd1) $display("[TB] FAIL rsv_id: got %0d expected 1", rsp_id); else passes++;
        @(negedge clock);
    endtask

    // Reset during EXEC discards the request; requester 1 is then served cleanly
    task automatic test_reset_mid();
        req_valid = 3'b100;
        req_op    = 6'b000000;
        req_a     = {8'hFF, 16'h0};
        req_b     = {8'h0F, 16'h0};
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b100) $display("[TB] FAIL rmid_grant: got %b expected 100", req_ready); else passes++;
        @(negedge clock);
        req_valid = 3'b000;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL rmid_busy_exec: got %b expected 1", busy); else passes++;
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rmid_busy_async: got %b expected 0", busy); else passes++;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL rmid_no_rsp: got %b expected 0", rsp_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rmid_busy_after: got %b expected 0", busy); else passes++;
        req_valid = 3'b010;
        req_a     = {8'h00, 8'hF0, 8'h00};
        req_b     = {8'h00, 8'h3C, 8'h00};
        #1;
        checks++; if (req_ready !== 3'b010) $display("[TB] FAIL rmid_grant1: got %b expected 010", req_ready); else passes++;
        @(negedge clock);
        req_valid = 3'b000;
        @(negedge clock);
        checks++; if (rsp_valid !== 1'b1) $display("[TB] FAIL rmid_valid1: got %b expected 1", rsp_valid); else passes++;
        checks++; if (rsp_id !== 2'd1) $display("[TB] FAIL rmid_id1: got %0d expected 1", rsp_id); else passes++;
        checks++; if (rsp_data !== 8'h30) $display("[TB] FAIL rmid_data1: got %h expected 30", rsp_data); else passes++;
        @(negedge clock);
    endtask

`ifdef LOGIC_OP_STATS_EN
    // Three completed handshakes counted from a fresh reset
    task automatic test_stats();
        pulse_reset();
        checks++; if (op_count !== 16'd0) $display("[TB] FAIL stats_reset: got %0d expected 0", op_count); else passes++;
        req_op    = 6'b000000;
        req_a     = {16'h0, 8'h0F};
        req_b     = {16'h0, 8'h3C};
        rsp_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            req_valid = 3'b001;
            @(negedge clock);
            req_valid = 3'b000;
            @(negedge clock);
            @(negedge clock);
        end
        checks++; if (op_count !== 16'd3) $display("[TB] FAIL stats_count: got %0d expected 3", op_count); else passes++;
    endtask
`endif

    // Scenario sequence
    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_and();
        test_hold();
        test_round_robin();
        test_reserved();
        test_reset_mid();
`ifdef LOGIC_OP_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
